// File: rtl/eth_rx_frame_ctrl_if.sv
// Receive-side bundle between the RMII deserializer/CRC engine, the frame controller and the rx buffer.
// The slave modport is the controller's view; the master modport drives the inputs and observes the results.
interface eth_rx_frame_ctrl_if #(
  parameter int pNUM_ETYPE = 2
);
  logic                      crs_dv_i;
  logic [1:0]                rxd_i;
  logic                      byte_rdy_i;
  logic [7:0]                rx_byte_i;
  logic [31:0]               crc_computed_i;
  logic [47:0]               mac_addr_i;
  logic                      promisc_i;
  logic                      etype_filt_en_i;
  logic [16*pNUM_ETYPE-1:0]  etype_list_i;

  logic                      rx_en_o;
  logic                      crc_en_o;
  logic                      pay_vld_o;
  logic                      pay_sof_o;
  logic [7:0]                pay_data_o;
  logic                      frame_done_o;
  logic                      frame_good_o;
  logic                      drop_o;
  logic                      err_crc_o;
  logic                      err_runt_o;
  logic                      err_giant_o;
  logic [2:0]                etype_idx_o;
  logic [15:0]               frame_len_o;

  modport slave (
    input  crs_dv_i, rxd_i, byte_rdy_i, rx_byte_i, crc_computed_i,
           mac_addr_i, promisc_i, etype_filt_en_i, etype_list_i,
    output rx_en_o, crc_en_o, pay_vld_o, pay_sof_o, pay_data_o,
           frame_done_o, frame_good_o, drop_o, err_crc_o, err_runt_o,
           err_giant_o, etype_idx_o, frame_len_o
  );

  modport master (
    output crs_dv_i, rxd_i, byte_rdy_i, rx_byte_i, crc_computed_i,
           mac_addr_i, promisc_i, etype_filt_en_i, etype_list_i,
    input  rx_en_o, crc_en_o, pay_vld_o, pay_sof_o, pay_data_o,
           frame_done_o, frame_good_o, drop_o, err_crc_o, err_runt_o,
           err_giant_o, etype_idx_o, frame_len_o
  );
endinterface

// File: rtl/eth_rx_frame_ctrl.sv
// RMII receive frame controller: preamble/SFD lock, DA + ethertype filtering, payload stream, length/CRC status.
// Payload one cycle after Byte_Rdy; Frame_Done two cycles after carrier loss or filter reject; no backpressure.
module eth_rx_frame_ctrl #(
  parameter int          pPREAMBLE_MIN = 31,
  parameter int          pNUM_ETYPE    = 2,
  parameter int          pMIN_FRAME    = 64,
  parameter int          pMAX_FRAME    = 1518,
  parameter logic [31:0] pCRC_RESIDUE  = 32'hDEBB20E3
) (
  input logic                clk_i,
  input logic                rst_i,
  eth_rx_frame_ctrl_if.slave rx_if
);

  localparam logic [7:0]  PRE_MIN = 8'(pPREAMBLE_MIN);
  localparam logic [15:0] MIN_LEN = 16'(pMIN_FRAME);
  localparam logic [16:0] MAX_LEN = 17'(pMAX_FRAME);

  typedef enum logic [1:0] {P_WAIT, P_IDLE, P_PRE, P_DATA} p_state_e;
  typedef enum logic [2:0] {B_IDLE, B_DA, B_SA, B_TYPE, B_BODY, B_END, B_DROP} b_state_e;

  typedef struct packed {
    logic        good;
    logic        drop;
    logic        err_crc;
    logic        err_runt;
    logic        err_giant;
    logic [2:0]  idx;
    logic [15:0] len;
  } status_t;

  p_state_e    p_state_q, p_state_d;
  logic [7:0]  pre_cnt_q, pre_cnt_d;
  logic        rx_en_q, rx_en_d;
  logic        crc_en_q, crc_en_d;

  b_state_e    b_state_q, b_state_d;
  logic [15:0] len_q, len_d;
  logic        ucast_q, ucast_d;
  logic        bcast_q, bcast_d;
  logic [7:0]  type_hi_q, type_hi_d;
  logic [2:0]  idx_q, idx_d;
  logic        giant_q, giant_d;
  logic        first_q, first_d;
  logic        pay_vld_q, pay_vld_d;
  logic        pay_sof_q, pay_sof_d;
  logic [7:0]  pay_data_q, pay_data_d;
  logic        done_q, done_d;
  status_t     status_q, status_d;

  logic        sfd_seen;
  logic        eof;
  logic        drop_req;
  logic        byte_acc;
  logic [5:0]  mac_sel;
  logic [7:0]  mac_byte;
  logic [15:0] etype_w;
  logic        etype_hit;
  logic [2:0]  etype_hit_idx;

  assign byte_acc = rx_if.byte_rdy_i & rx_en_q;
  assign mac_sel  = 6'd40 - {len_q[2:0], 3'b000};
  assign mac_byte = rx_if.mac_addr_i[mac_sel +: 8];
  assign etype_w  = {type_hi_q, rx_if.rx_byte_i};

  // Scan from the top so the lowest matching entry wins.
  always_comb begin
    etype_hit     = 1'b0;
    etype_hit_idx = 3'd0;
    for (int i = pNUM_ETYPE - 1; i >= 0; i--) begin
      if (rx_if.etype_list_i[16*i +: 16] == etype_w) begin
        etype_hit     = 1'b1;
        etype_hit_idx = 3'(i);
      end
    end
  end

  always_comb begin
    p_state_d = p_state_q;
    pre_cnt_d = pre_cnt_q;
    rx_en_d   = rx_en_q;
    crc_en_d  = crc_en_q;
    sfd_seen  = 1'b0;
    eof       = 1'b0;
    case (p_state_q)
      P_WAIT: if (!rx_if.crs_dv_i) p_state_d = P_IDLE;
      P_IDLE: begin
        if (rx_if.crs_dv_i && rx_if.rxd_i == 2'b01) begin
          p_state_d = P_PRE;
          pre_cnt_d = 8'd1;
        end
      end
      P_PRE: begin
        if (rx_if.crs_dv_i && rx_if.rxd_i == 2'b01) begin
          if (pre_cnt_q != 8'hFF) pre_cnt_d = pre_cnt_q + 8'd1;
        end else if (rx_if.crs_dv_i && rx_if.rxd_i == 2'b11 && pre_cnt_q >= PRE_MIN) begin
          p_state_d = P_DATA;
          rx_en_d   = 1'b1;
          crc_en_d  = 1'b1;
          sfd_seen  = 1'b1;
        end else begin
          p_state_d = P_IDLE;
        end
      end
      P_DATA: begin
        if (!rx_if.crs_dv_i) begin
          p_state_d = P_IDLE;
          rx_en_d   = 1'b0;
          eof       = 1'b1;
        end else if (drop_req) begin
          // Wait for carrier to drop so we never relock inside the rejected frame.
          p_state_d = P_WAIT;
          rx_en_d   = 1'b0;
        end
      end
      default: p_state_d = P_WAIT;
    endcase
    if (drop_req || b_state_q == B_END) crc_en_d = 1'b0;
  end

  always_comb begin
    b_state_d  = b_state_q;
    len_d      = len_q;
    ucast_d    = ucast_q;
    bcast_d    = bcast_q;
    type_hi_d  = type_hi_q;
    idx_d      = idx_q;
    giant_d    = giant_q;
    first_d    = first_q;
    pay_vld_d  = 1'b0;
    pay_sof_d  = 1'b0;
    pay_data_d = pay_data_q;
    done_d     = 1'b0;
    status_d   = status_q;
    drop_req   = 1'b0;

    if (byte_acc && b_state_q != B_IDLE && len_q != 16'hFFFF) len_d = len_q + 16'd1;

    case (b_state_q)
      B_IDLE: begin
        if (sfd_seen) begin
          b_state_d = B_DA;
          len_d     = 16'd0;
          ucast_d   = 1'b1;
          bcast_d   = 1'b1;
          idx_d     = 3'd0;
          giant_d   = 1'b0;
          first_d   = 1'b1;
        end
      end
      B_DA: begin
        if (byte_acc) begin
          ucast_d = ucast_q & (rx_if.rx_byte_i == mac_byte);
          bcast_d = bcast_q & (rx_if.rx_byte_i == 8'hFF);
          if (len_q == 16'd5) begin
            if (rx_if.promisc_i || ucast_d || bcast_d) b_state_d = B_SA;
            else                                       drop_req  = 1'b1;
          end
        end
      end
      B_SA: if (byte_acc && len_q == 16'd11) b_state_d = B_TYPE;
      B_TYPE: begin
        if (byte_acc) begin
          if (len_q == 16'd12) begin
            type_hi_d = rx_if.rx_byte_i;
          end else if (rx_if.etype_filt_en_i && !etype_hit) begin
            drop_req = 1'b1;
          end else begin
            b_state_d = B_BODY;
            idx_d     = rx_if.etype_filt_en_i ? etype_hit_idx : 3'd0;
          end
        end
      end
      B_BODY: begin
        if (byte_acc) begin
          if (({1'b0, len_q} + 17'd1) > MAX_LEN) begin
            giant_d = 1'b1;
          end else begin
            pay_vld_d  = 1'b1;
            pay_sof_d  = first_q;
            pay_data_d = rx_if.rx_byte_i;
            first_d    = 1'b0;
          end
        end
      end
      B_END: begin
        done_d             = 1'b1;
        status_d.drop      = 1'b0;
        status_d.err_crc   = (rx_if.crc_computed_i != pCRC_RESIDUE);
        status_d.err_runt  = (len_q < MIN_LEN);
        status_d.err_giant = giant_q;
        status_d.idx       = idx_q;
        status_d.len       = len_q;
        status_d.good      = ~status_d.err_crc & ~status_d.err_runt & ~status_d.err_giant;
        b_state_d          = B_IDLE;
      end
      B_DROP: begin
        done_d        = 1'b1;
        status_d      = '0;
        status_d.drop = 1'b1;
        status_d.idx  = idx_q;
        status_d.len  = len_q;
        b_state_d     = B_IDLE;
      end
      default: b_state_d = B_IDLE;
    endcase

    if (drop_req) b_state_d = B_DROP;
    else if (eof && b_state_q inside {B_DA, B_SA, B_TYPE, B_BODY}) b_state_d = B_END;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p_state_q  <= P_WAIT;
      pre_cnt_q  <= 8'd0;
      rx_en_q    <= 1'b0;
      crc_en_q   <= 1'b0;
      b_state_q  <= B_IDLE;
      len_q      <= 16'd0;
      ucast_q    <= 1'b0;
      bcast_q    <= 1'b0;
      type_hi_q  <= 8'd0;
      idx_q      <= 3'd0;
      giant_q    <= 1'b0;
      first_q    <= 1'b0;
      pay_vld_q  <= 1'b0;
      pay_sof_q  <= 1'b0;
      pay_data_q <= 8'd0;
      done_q     <= 1'b0;
      status_q   <= '0;
    end else begin
      p_state_q  <= p_state_d;
      pre_cnt_q  <= pre_cnt_d;
      rx_en_q    <= rx_en_d;
      crc_en_q   <= crc_en_d;
      b_state_q  <= b_state_d;
      len_q      <= len_d;
      ucast_q    <= ucast_d;
      bcast_q    <= bcast_d;
      type_hi_q  <= type_hi_d;
      idx_q      <= idx_d;
      giant_q    <= giant_d;
      first_q    <= first_d;
      pay_vld_q  <= pay_vld_d;
      pay_sof_q  <= pay_sof_d;
      pay_data_q <= pay_data_d;
      done_q     <= done_d;
      status_q   <= status_d;
    end
  end

  assign rx_if.rx_en_o      = rx_en_q;
  assign rx_if.crc_en_o     = crc_en_q;
  assign rx_if.pay_vld_o    = pay_vld_q;
  assign rx_if.pay_sof_o    = pay_sof_q;
  assign rx_if.pay_data_o   = pay_data_q;
  assign rx_if.frame_done_o = done_q;
  assign rx_if.frame_good_o = status_q.good;
  assign rx_if.drop_o       = status_q.drop;
  assign rx_if.err_crc_o    = status_q.err_crc;
  assign rx_if.err_runt_o   = status_q.err_runt;
  assign rx_if.err_giant_o  = status_q.err_giant;
  assign rx_if.etype_idx_o  = status_q.idx;
  assign rx_if.frame_len_o  = status_q.len;

endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// Bench for eth_rx_frame_ctrl: frame-level reference model feeds payload/status queues, a negedge monitor checks them.
module tb_eth_rx_frame_ctrl;
  localparam int          NE   = 2;
  localparam int          MINF = 64;
  localparam int          MAXF = 1518;
  localparam logic [31:0] RES  = 32'hDEBB20E3;
  localparam logic [47:0] MAC  = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BC   = 48'hFF_FF_FF_FF_FF_FF;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  eth_rx_frame_ctrl_if #(.pNUM_ETYPE(NE)) rx_if ();
  eth_rx_frame_ctrl #(.pNUM_ETYPE(NE)) dut (.clk_i(clk), .rst_i(rst), .rx_if(rx_if));

  typedef struct { logic [7:0] d; logic sof; } pay_t;
  typedef struct {
    int cyc; logic good; logic drop; logic ecrc; logic runt; logic giant;
    logic [2:0] idx; logic [15:0] len;
  } st_t;

  pay_t       pay_q[$];
  st_t        st_q[$];
  logic [7:0] fr[$];
  pay_t       pe;
  st_t        se;

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // External CRC engine: held at init while disabled, accumulates accepted bytes.
  logic [31:0] crc_q = 32'hFFFF_FFFF;
  always @(posedge clk) begin
    if (!rx_if.crc_en_o)       crc_q <= 32'hFFFF_FFFF;
    else if (rx_if.byte_rdy_i) crc_q <= crc_upd(crc_q, rx_if.rx_byte_i);
  end
  assign rx_if.crc_computed_i = crc_q;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rx_if.pay_vld_o === 1'b1) begin
      if (pay_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL pay_unexpected actual data=%0h required none (cycle %0d)", rx_if.pay_data_o, cyc);
      end else begin
        pe = pay_q.pop_front();
        chk("payload", {rx_if.pay_sof_o, rx_if.pay_data_o}, {pe.sof, pe.d});
      end
    end
    if (rx_if.frame_done_o === 1'b1) begin
      if (st_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL done_unexpected actual frame_done=1 required none (cycle %0d)", cyc);
      end else begin
        se = st_q.pop_front();
        chk("done_cycle", cyc, se.cyc);
        chk("status", {rx_if.frame_good_o, rx_if.drop_o, rx_if.err_crc_o, rx_if.err_runt_o,
                       rx_if.err_giant_o, rx_if.etype_idx_o, rx_if.frame_len_o},
                      {se.good, se.drop, se.ecrc, se.runt, se.giant, se.idx, se.len});
      end
    end
  end

  task automatic slot(input logic crs, input logic [1:0] d, input logic br, input logic [7:0] b);
    @(posedge clk); #1;
    rx_if.crs_dv_i   = crs;
    rx_if.rxd_i      = d;
    rx_if.byte_rdy_i = br;
    rx_if.rx_byte_i  = b;
  endtask

  task automatic build(input logic [47:0] da, input logic [15:0] et, input int n);
    logic [31:0] c;
    fr.delete();
    for (int i = 0; i < 6; i++) fr.push_back(da[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) fr.push_back(8'(8'h40 + i));
    fr.push_back(et[15:8]);
    fr.push_back(et[7:0]);
    while (fr.size() < n - 4) fr.push_back(8'($urandom));
    c = 32'hFFFF_FFFF;
    foreach (fr[i]) c = crc_upd(c, fr[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) fr.push_back(c[8*i +: 8]);
  endtask

  // Drives one frame; tail=0 drops carrier with the last byte, rst_idx>=0 resets in place of that byte.
  task automatic send_frame(input int pre_len, input int tail, input int rst_idx);
    int          n, drop_at;
    bit          pre_ok, da_ok, et_ok, aborted, last;
    logic [2:0]  eidx;
    logic [31:0] c;
    logic [15:0] et;
    logic [47:0] da;
    st_t         s;

    n      = fr.size();
    pre_ok = (pre_len >= 31);
    da     = {fr[0], fr[1], fr[2], fr[3], fr[4], fr[5]};
    et     = {fr[12], fr[13]};
    da_ok  = rx_if.promisc_i || da == rx_if.mac_addr_i || da == BC;
    et_ok  = 1'b0;
    eidx   = 3'd0;
    for (int i = 0; i < NE; i++) begin
      if (!et_ok && rx_if.etype_list_i[16*i +: 16] == et) begin
        et_ok = 1'b1;
        eidx  = 3'(i);
      end
    end
    if (!rx_if.etype_filt_en_i) eidx = 3'd0;
    drop_at = -1;
    if (!da_ok) drop_at = 5;
    else if (rx_if.etype_filt_en_i && !et_ok) drop_at = 13;

    c = 32'hFFFF_FFFF;
    foreach (fr[i]) c = crc_upd(c, fr[i]);
    s.cyc   = 0;
    s.len   = 16'(n);
    s.drop  = 1'b0;
    s.ecrc  = (c != RES);
    s.runt  = (n < MINF);
    s.giant = (n > MAXF);
    s.idx   = eidx;
    s.good  = !(s.ecrc || s.runt || s.giant);
    if (drop_at >= 0) begin
      s.len  = 16'(drop_at + 1);
      s.drop = 1'b1; s.ecrc = 1'b0; s.runt = 1'b0; s.giant = 1'b0; s.good = 1'b0;
      s.idx  = 3'd0;
    end

    repeat (3) slot(1'b0, 2'b00, 1'b0, 8'h00);
    repeat (pre_len) slot(1'b1, 2'b01, 1'b0, 8'h00);
    slot(1'b1, 2'b11, 1'b0, 8'h00);
    aborted = 1'b0;
    for (int i = 0; i < n; i++) begin
      repeat (3) slot(1'b1, 2'b00, 1'b0, 8'h00);
      if (i == rst_idx) begin
        slot(1'b1, 2'b00, 1'b0, 8'h00);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midframe_reset_outputs", {rx_if.rx_en_o, rx_if.crc_en_o, rx_if.pay_vld_o, rx_if.frame_done_o,
                                       rx_if.frame_good_o, rx_if.frame_len_o}, 64'h0);
        aborted = 1'b1;
      end else begin
        last = (i == n - 1) && (tail == 0);
        slot(!last, 2'b00, 1'b1, fr[i]);
        if (!pre_ok) chk("short_preamble_rx_en", rx_if.rx_en_o, 1'b0);
        if (pre_ok && !aborted) begin
          if (drop_at < 0 && i >= 14 && i < MAXF) pay_q.push_back('{d: fr[i], sof: (i == 14)});
          if (i == drop_at) begin s.cyc = cyc + 2; st_q.push_back(s); end
          if (drop_at >= 0 && i > drop_at) chk("rx_en_after_drop", rx_if.rx_en_o, 1'b0);
          if (last && drop_at < 0) begin s.cyc = cyc + 2; st_q.push_back(s); end
        end
      end
    end
    if (tail > 0) begin
      repeat (tail) slot(1'b1, 2'b00, 1'b0, 8'h00);
      slot(1'b0, 2'b00, 1'b0, 8'h00);
      if (pre_ok && !aborted && drop_at < 0) begin s.cyc = cyc + 2; st_q.push_back(s); end
    end
    repeat (4) slot(1'b0, 2'b00, 1'b0, 8'h00);
  endtask

  initial begin
    logic [63:0] r64;
    logic [47:0] rda;
    logic [15:0] ret;
    int          j;

    rst                   = 1'b1;
    rx_if.crs_dv_i        = 1'b0;
    rx_if.rxd_i           = 2'b00;
    rx_if.byte_rdy_i      = 1'b0;
    rx_if.rx_byte_i       = 8'h00;
    rx_if.mac_addr_i      = MAC;
    rx_if.promisc_i       = 1'b0;
    rx_if.etype_filt_en_i = 1'b0;
    rx_if.etype_list_i    = {16'h0806, 16'h0800};
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_outputs", {rx_if.rx_en_o, rx_if.crc_en_o, rx_if.pay_vld_o, rx_if.pay_sof_o, rx_if.pay_data_o,
                          rx_if.frame_done_o, rx_if.frame_good_o, rx_if.drop_o, rx_if.err_crc_o,
                          rx_if.err_runt_o, rx_if.err_giant_o, rx_if.etype_idx_o, rx_if.frame_len_o}, 64'h0);

    build(MAC, 16'h0800, 64);                   send_frame(31, 1, -1);
    build(BC, 16'h0800, 64);                    send_frame(35, 0, -1);
    build(48'h02_00_00_00_00_02, 16'h0800, 64); send_frame(31, 2, -1);
    rx_if.etype_filt_en_i = 1'b1;
    build(MAC, 16'h0806, 64);                   send_frame(31, 1, -1);
    build(MAC, 16'h86DD, 64);                   send_frame(31, 1, -1);
    rx_if.etype_filt_en_i = 1'b0;
    build(MAC, 16'h0800, 64); fr[62] = fr[62] ^ 8'h40; send_frame(31, 1, -1);
    build(MAC, 16'h0800, 40);                   send_frame(32, 0, -1);
    build(MAC, 16'h0800, 1522);                 send_frame(31, 1, -1);
    build(MAC, 16'h0800, 64);                   send_frame(20, 1, -1);
    build(MAC, 16'h0800, 100);                  send_frame(31, 1, 30);
    build(MAC, 16'h0800, 64);                   send_frame(31, 1, -1);
    rx_if.promisc_i = 1'b1;
    build(48'h12_34_56_78_9A_BC, 16'h0800, 70); send_frame(33, 3, -1);

    for (int k = 0; k < 16; k++) begin
      r64 = {$urandom(), $urandom()};
      case ($urandom_range(0, 2))
        0:       rda = MAC;
        1:       rda = BC;
        default: rda = r64[47:0];
      endcase
      case ($urandom_range(0, 3))
        0:       ret = 16'h0800;
        1:       ret = 16'h0806;
        2:       ret = 16'h86DD;
        default: ret = 16'($urandom);
      endcase
      rx_if.promisc_i       = ($urandom_range(0, 3) == 0);
      rx_if.etype_filt_en_i = 1'($urandom_range(0, 1));
      build(rda, ret, $urandom_range(40, 160));
      if ($urandom_range(0, 3) == 0) begin
        j = $urandom_range(0, fr.size() - 1);
        fr[j] = fr[j] ^ 8'(1 << $urandom_range(0, 7));
      end
      send_frame($urandom_range(31, 40), $urandom_range(0, 3), -1);
    end

    repeat (10) slot(1'b0, 2'b00, 1'b0, 8'h00);
    chk("payload_queue_drained", pay_q.size(), 0);
    chk("status_queue_drained", st_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/eth_rx_frame_ctrl.md
Name: eth_rx_frame_ctrl

Overview:
Parametrised RMII receive frame controller, the successor to the single-ethertype rx control block. It sits between the RMII dibit/byte deserializer plus external CRC-32 engine and the receive buffer. It adds:
- minimum-length preamble detection;
- destination MAC filtering (unicast, broadcast, promiscuous);
- an N-entry ethertype filter;
- a payload byte stream;
- runt and giant length checks;
- CRC residue check;
- a per-frame status report.

Parameters:
pPREAMBLE_MIN, 31, minimum count of consecutive 01 dibits before the SFD 11 dibit
pNUM_ETYPE, 2, number of ethertype filter entries (1..8)
pMIN_FRAME, 64, minimum legal frame length in bytes, DA through FCS inclusive
pMAX_FRAME, 1518, maximum legal frame length in bytes, DA through FCS inclusive
pCRC_RESIDUE, 32'hDEBB20E3, value Crc_Computed presents after a correct FCS has been accumulated

Ports:
Clk  in  1  system clock (RMII 50 MHz domain)
Rst  in  1  synchronous, active-high reset
Crs_Dv  in  1  RMII carrier sense / data valid
Rxd  in  2  RMII receive dibit
Byte_Rdy  in  1  1-cycle strobe: Byte holds a new assembled byte
Byte  in  8  assembled receive byte
Crc_Computed  in  32  running CRC from external engine (cleared while Crc_En=0; accumulates Byte on Byte_Rdy&Crc_En)
Mac_Addr  in  48  station address; first received byte compares to [47:40]
Promisc  in  1  accept any DA
Etype_Filt_En  in  1  enable ethertype filter
Etype_List  in  16*pNUM_ETYPE  accepted ethertypes; entry i at [16i+15:16i]
Rx_En  out  1  frame data phase active (to deserializer)
Crc_En  out  1  CRC engine enable
Pay_Vld  out  1  payload byte strobe
Pay_Sof  out  1  high with the first Pay_Vld of a frame
Pay_Data  out  8  payload byte
Frame_Done  out  1  1-cycle status strobe
Frame_Good  out  1  frame accepted, no errors
Drop  out  1  filtered by DA or ethertype
Err_Crc  out  1  CRC residue mismatch
Err_Runt  out  1  Frame_Len < pMIN_FRAME
Err_Giant  out  1  Frame_Len > pMAX_FRAME
Etype_Idx  out  3  lowest matching Etype_List index
Frame_Len  out  16  bytes received, DA..FCS, saturating at 16'hFFFF

Behaviour:
- Reset: all outputs 0. Dibit FSM goes to P_WAIT; byte FSM goes to B_IDLE; all counters 0.
- Dibit FSM:
  - P_WAIT: exit to P_IDLE on the first cycle with Crs_Dv=0. This guarantees no mid-frame lock after reset or drop.
  - P_IDLE: Crs_Dv & Rxd=01 -> P_PRE, with count=1.
  - P_PRE: Crs_Dv & 01 -> count+1 (saturates at 255). Crs_Dv & 11 & count>=pPREAMBLE_MIN -> P_DATA, with Rx_En<=1 and Crc_En<=1 (registered). Any other input -> P_IDLE.
  - P_DATA: Crs_Dv=0 -> P_IDLE with Rx_En<=0. A drop request from the byte FSM -> P_WAIT with Rx_En<=0.
- Byte FSM (advances only on Byte_Rdy while Rx_En=1, except the end-of-frame check below):
  - Every Byte_Rdy increments Frame_Len.
  - B_DA (6 bytes): track ucast_match (byte k vs Mac_Addr[47-8k -: 8]) and bcast_match (all 8'hFF). After the 6th byte: pass if Promisc|ucast|bcast; otherwise drop.
  - B_TYPE (2 bytes, big-endian): if Etype_Filt_En and no entry matches -> drop. Etype_Idx <= lowest matching index, or 0 if no match or filter disabled.
  - B_BODY: each byte produces Pay_Vld=1 and Pay_Data=Byte one cycle after Byte_Rdy. The stream includes the 4 FCS bytes. Pay_Sof marks the first body byte. Once Frame_Len exceeds pMAX_FRAME, Pay_Vld is suppressed and Err_Giant latched; counting continues.
  - End of frame: the cycle Crs_Dv=0 is seen in P_DATA, the byte FSM enters B_END.
    - A Byte_Rdy coincident with Crs_Dv falling is still counted and forwarded.
    - B_END (1 cycle): Crc_En<=0; Err_Crc = (Crc_Computed != pCRC_RESIDUE); Err_Runt = Frame_Len < pMIN_FRAME.
    - Frame_Done pulses one cycle later with all status valid. Then -> B_IDLE.
  - Drop: Frame_Done pulses with Drop=1, Frame_Good=0, Err_* =0, Frame_Len equal to the bytes seen so far. There is no further Pay_Vld. Crc_En<=0.
  - Carrier loss in B_DA/B_TYPE: normal B_END path; Err_Runt=1.
- Status outputs hold from one Frame_Done until the next Frame_Done or reset. Frame_Good = ~Drop & ~Err_Crc & ~Err_Runt & ~Err_Giant.
- Rst mid-frame: immediate return to the reset state. No Frame_Done is issued for the aborted frame.

Test Plan:
- 64-byte frame, DA=Mac_Addr=02:00:00:00:00:01, valid FCS, filter off -> 50 Pay_Vld strobes (first with Pay_Sof); Frame_Done with Frame_Good=1, Frame_Len=64, all errors 0.
- DA FF:FF:FF:FF:FF:FF, Promisc=0 -> accepted, Good=1. DA 02:00:00:00:00:02 -> Frame_Done with Drop=1 and Frame_Len=6 two cycles after the 6th Byte_Rdy; no Pay_Vld; Rx_En stays 0 until Crs_Dv falls and a new preamble arrives.
- Etype_List={0x0806,0x0800}, filter on: ethertype 0x0806 -> Good, Etype_Idx=1. Ethertype 0x86DD -> Drop=1 after byte 14.
- One FCS byte flipped -> Err_Crc=1, Frame_Good=0, Frame_Len=64.
- 40-byte frame -> Err_Runt=1. 1522-byte frame -> Err_Giant=1, last Pay_Vld on byte 1518, Frame_Len=1522.
- Preamble of 20 01-dibits then 11 -> Rx_En never asserts. Rst asserted mid-payload -> no Frame_Done; the next full frame after Crs_Dv low is received with Good=1.
